// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared FSM state encoding and error codes for the serial boot loader
package boot_loader_pkg;
  typedef enum logic [2:0] {HDR, CHK_LEN, DATA, CSUM, DONE, ERROR} bl_state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
endpackage

// File: rtl/boot_loader_byte_packer.sv
// boot_loader_byte_packer: packs four LSB-first bytes into a word; word is valid while word_done pulses
module boot_loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_done
);
  logic [1:0]  r_byte_idx;
  logic [31:0] r_word;
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_byte_idx <= '0;
      r_word     <= '0;
    end else if (in_valid) begin
      r_byte_idx <= r_byte_idx + 2'd1;
      r_word     <= word;
    end
  end
  // the current byte lands in the top lane so the first byte ends up in bits [7:0]
  assign word      = {in_byte, r_word[31:8]};
  assign word_done = in_valid && r_byte_idx == 2'd3;
endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed, XOR-checksummed byte frame, writes it to memory
// from BASE_ADDR and releases the core from reset once the image is verified.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);
  localparam int IW = $clog2(MAX_WORDS + 1);
  bl_state_t   r_state, w_next;
  logic [31:0] r_n, r_mem_addr, r_mem_wdata;
  logic [IW-1:0] r_word_idx;
  logic [7:0]  r_csum;
  logic        r_mem_we;
  logic [1:0]  r_err_code;
  logic        w_xfer, w_pk_valid, w_word_done, w_len_bad, w_last;
  logic [31:0] w_word;
  assign byte_ready = r_state inside {HDR, DATA, CSUM};
  assign w_xfer     = byte_valid && byte_ready;
  assign w_pk_valid = w_xfer && r_state != CSUM;
  assign w_len_bad  = r_n == '0 || r_n > 32'(MAX_WORDS);
  assign w_last     = 32'(r_word_idx) + 32'd1 == r_n;
  boot_loader_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (r_state == CHK_LEN),
    .in_valid  (w_pk_valid),
    .in_byte   (byte_in),
    .word      (w_word),
    .word_done (w_word_done)
  );
  always_ff @(posedge clk) begin
    if (reset) r_state <= HDR;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      HDR:     w_next = w_word_done ? CHK_LEN : HDR;
      CHK_LEN: w_next = w_len_bad ? ERROR : DATA;
      DATA:    w_next = (w_word_done && w_last) ? CSUM : DATA;
      CSUM:    w_next = w_xfer ? (byte_in == r_csum ? DONE : ERROR) : CSUM;
      default: w_next = r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n         <= '0;
      r_word_idx  <= '0;
      r_csum      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wdata <= '0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_mem_we <= 1'b0;
      if (r_state == HDR && w_word_done) r_n <= w_word;
      if (r_state == CHK_LEN) begin
        r_word_idx <= '0;
        if (w_len_bad) r_err_code <= ERR_LEN;
      end
      if (r_state == DATA && w_xfer) r_csum <= r_csum ^ byte_in;
      // the write-out is a single registered pulse so intake never waits on it
      if (r_state == DATA && w_word_done) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= BASE_ADDR + (32'(r_word_idx) << 2);
        r_mem_wdata <= w_word;
        r_word_idx  <= r_word_idx + IW'(1);
      end
      if (r_state == CSUM && w_xfer && byte_in != r_csum) r_err_code <= ERR_CSUM;
    end
  end
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign cpu_reset = r_state != DONE;
  assign done      = r_state == DONE;
  assign error     = r_state == ERROR;
  assign err_code  = r_err_code;
endmodule
